// File: rtl/config_writer_if.sv
// Command handshake from the host plus the 2-bit config write bus toward
// the register block.
interface config_writer_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] config_addr;
    logic [1:0] config_data;
    logic       config_en;

    modport master (
        output cmd_data, cmd_valid,
        input  cmd_ready, config_addr, config_data, config_en
    );

    modport slave (
        input  cmd_data, cmd_valid,
        output cmd_ready, config_addr, config_data, config_en
    );
endinterface

// File: rtl/config_writer.sv
// Config write initiator: decodes parity-checked host command bytes into
// single, broadcast or load-defaults strobe sequences and shadows the results.
module config_writer #(
    parameter logic [1:0] CH0_REG_ADDR    = 2'h0,
    parameter logic [1:0] CH1_REG_ADDR    = 2'h1,
    parameter logic [1:0] CH2_REG_ADDR    = 2'h2,
    parameter logic [1:0] CRC_EN_REG_ADDR = 2'h3,
    parameter logic [1:0] DEF_CH0         = 2'h0,
    parameter logic [1:0] DEF_CH1         = 2'h1,
    parameter logic [1:0] DEF_CH2         = 2'h2,
    parameter logic       DEF_CRC_EN      = 1'b0,
    parameter bit         PARITY_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    config_writer_if.slave  bus,
    output logic            busy,
    output logic            cmd_err,
    output logic [7:0]      err_cnt,
    output logic [1:0]      sh_ch0,
    output logic [1:0]      sh_ch1,
    output logic [1:0]      sh_ch2,
    output logic            sh_crc_en
);
    typedef enum logic [1:0] {IDLE, WR, SEQ} state_t;

    state_t     state, state_d;
    logic [1:0] step, step_d;
    logic       bcast, bcast_d;
    logic [1:0] seq_data, seq_data_d;
    logic [1:0] addr_q, addr_d, data_q, data_d;
    logic       err_d;
    logic       accept, par_ok;

    // {addr, data} for a given step of a broadcast or load-defaults sequence
    function automatic logic [3:0] seq_word(input logic bc, input logic [1:0] st,
                                            input logic [1:0] d);
        case (st)
            2'd0:    return {CH0_REG_ADDR, bc ? d : DEF_CH0};
            2'd1:    return {CH1_REG_ADDR, bc ? d : DEF_CH1};
            2'd2:    return {CH2_REG_ADDR, bc ? d : DEF_CH2};
            default: return {CRC_EN_REG_ADDR, 1'b0, DEF_CRC_EN};
        endcase
    endfunction

    assign bus.cmd_ready   = (state == IDLE) && rst_n;
    assign accept          = bus.cmd_valid && bus.cmd_ready;
    assign par_ok          = !PARITY_EN || !(^bus.cmd_data);
    assign bus.config_en   = (state != IDLE);
    assign bus.config_addr = addr_q;
    assign bus.config_data = data_q;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= 2'd0;
            bcast    <= 1'b0;
            seq_data <= 2'd0;
            addr_q   <= 2'd0;
            data_q   <= 2'd0;
        end else begin
            state    <= state_d;
            step     <= step_d;
            bcast    <= bcast_d;
            seq_data <= seq_data_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d    = state;
        step_d     = step;
        bcast_d    = bcast;
        seq_data_d = seq_data;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    // parity gates decode: a bad byte is never interpreted
                    if (!par_ok) begin
                        err_d = 1'b1;
                    end else begin
                        case (bus.cmd_data[7:6])
                            2'b01: begin
                                state_d = WR;
                                addr_d  = bus.cmd_data[3:2];
                                data_d  = bus.cmd_data[1:0];
                            end
                            2'b10, 2'b11: begin
                                state_d         = SEQ;
                                step_d          = 2'd0;
                                bcast_d         = !bus.cmd_data[6];
                                seq_data_d      = bus.cmd_data[1:0];
                                {addr_d, data_d} = seq_word(!bus.cmd_data[6], 2'd0,
                                                            bus.cmd_data[1:0]);
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WR: state_d = IDLE;
            SEQ: begin
                if (step == (bcast ? 2'd2 : 2'd3)) begin
                    state_d = IDLE;
                end else begin
                    step_d           = step + 2'd1;
                    {addr_d, data_d} = seq_word(bcast, step + 2'd1, seq_data);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_err   <= 1'b0;
            err_cnt   <= 8'h00;
            sh_ch0    <= 2'd0;
            sh_ch1    <= 2'd0;
            sh_ch2    <= 2'd0;
            sh_crc_en <= 1'b0;
        end else begin
            cmd_err <= err_d;
            if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            // unmatched addresses still strobe but touch no shadow
            if (bus.config_en) begin
                if (addr_q == CH0_REG_ADDR)    sh_ch0    <= data_q;
                if (addr_q == CH1_REG_ADDR)    sh_ch1    <= data_q;
                if (addr_q == CH2_REG_ADDR)    sh_ch2    <= data_q;
                if (addr_q == CRC_EN_REG_ADDR) sh_crc_en <= data_q[0];
            end
        end
    end
endmodule

// File: tb/tb_config_writer.sv
// Self-checking bench for config_writer: table vectors, hand-written
// multi-cycle sequences and randomized commands against a write-list model.
module tb_config_writer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    config_writer_if bus();
    logic       busy, cmd_err, sh_crc_en;
    logic [7:0] err_cnt;
    logic [1:0] sh_ch0, sh_ch1, sh_ch2;

    config_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .cmd_err   (cmd_err),
        .err_cnt   (err_cnt),
        .sh_ch0    (sh_ch0),
        .sh_ch1    (sh_ch1),
        .sh_ch2    (sh_ch2),
        .sh_crc_en (sh_crc_en)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: a command expands to a list of {addr,data} writes; shadows are an
    // array indexed by register address.
    logic [1:0] m_sh[4];
    int         m_err;
    logic [3:0] exp_q[$];

    function automatic bit model_cmd(input logic [7:0] c);
        logic [3:0] w[$];
        w = {};
        if (^c) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            return 1'b1;
        end
        case (c[7:6])
            2'b01: w.push_back({c[3:2], c[1:0]});
            2'b10: for (int a = 0; a < 3; a++) w.push_back({2'(a), c[1:0]});
            2'b11: w = {4'b0000, 4'b0101, 4'b1010, 4'b1100};
            default: ;
        endcase
        foreach (w[i]) begin
            m_sh[w[i][3:2]] = (w[i][3:2] == 2'd3) ? {1'b0, w[i][0]} : w[i][1:0];
            exp_q.push_back(w[i]);
        end
        return 1'b0;
    endfunction

    function automatic logic [6:0] m_shadows();
        return {m_sh[0], m_sh[1], m_sh[2], m_sh[3][0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_sh[i] = 2'd0;
        m_err = 0;
    endfunction

    wire [6:0] dut_sh = {sh_ch0, sh_ch1, sh_ch2, sh_crc_en};

    // {busy, cmd_ready, config_en, addr, data, cmd_err}; addr/data masked when idle
    function automatic logic [7:0] obs();
        return {busy, bus.cmd_ready, bus.config_en,
                bus.config_en ? {bus.config_addr, bus.config_data} : 4'h0, cmd_err};
    endfunction

    function automatic logic [7:0] exp_strobe(input logic [3:0] w);
        return {1'b1, 1'b0, 1'b1, w, 1'b0};
    endfunction

    function automatic logic [7:0] exp_idle(input bit err);
        return {1'b0, 1'b1, 1'b0, 4'h0, err};
    endfunction

    task automatic run_cmd(input logic [7:0] c, output int n_obs, output bit err_obs);
        bit bad;
        int wn;
        exp_q.delete();
        bad = model_cmd(c);
        n_obs = 0;
        err_obs = 1'b0;
        @(negedge clk);
        wn = 0;
        while (bus.cmd_ready !== 1'b1 && wn < 20) begin
            @(negedge clk);
            wn++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            chk("ready_timeout", {31'd0, bus.cmd_ready}, 32'd1);
            return;
        end
        bus.cmd_data  = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("cmd%02h_cyc%0d", c, i), {24'd0, obs()},
                {24'd0, (i < exp_q.size()) ? exp_strobe(exp_q[i]) : exp_idle(i == 0 && bad)});
            n_obs += int'(bus.config_en);
            err_obs |= cmd_err;
        end
        chk($sformatf("cmd%02h_shadow", c), {25'd0, dut_sh}, {25'd0, m_shadows()});
        chk($sformatf("cmd%02h_errcnt", c), {24'd0, err_cnt}, 32'(m_err));
    endtask

    typedef struct {
        logic [7:0] cmd;
        int         n;
        bit         err;
        logic [6:0] sh;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   n;
        bit   e;
        int   en_cnt;
        logic [7:0] c;

        tbl[0] = '{8'h66, 1, 1'b0, {2'd0, 2'd2, 2'd0, 1'b0}};  // WRITE ch1 <= 2
        tbl[1] = '{8'hA3, 3, 1'b0, {2'd3, 2'd3, 2'd3, 1'b0}};  // BROADCAST 3
        tbl[2] = '{8'hC0, 4, 1'b0, {2'd0, 2'd1, 2'd2, 1'b0}};  // LOAD_DEFAULTS
        tbl[3] = '{8'h46, 0, 1'b1, {2'd0, 2'd1, 2'd2, 1'b0}};  // bad parity
        tbl[4] = '{8'h0F, 0, 1'b0, {2'd0, 2'd1, 2'd2, 1'b0}};  // NOP
        tbl[5] = '{8'h5F, 1, 1'b0, {2'd0, 2'd1, 2'd2, 1'b1}};  // WRITE crc <= 3, bit4 set
        tbl[6] = '{8'h93, 3, 1'b0, {2'd3, 2'd3, 2'd3, 1'b1}};  // BROADCAST 3, bit4 set
        tbl[7] = '{8'hC0, 4, 1'b0, {2'd0, 2'd1, 2'd2, 1'b0}};

        model_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {24'd0, obs()}, 32'd0);
        chk("reset_errcnt", {24'd0, err_cnt}, 32'd0);
        chk("reset_shadow", {25'd0, dut_sh}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].cmd, n, e);
            chk($sformatf("tbl%0d_nstrobe", i), 32'(n), 32'(tbl[i].n));
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].err});
            chk($sformatf("tbl%0d_shadow", i), {25'd0, dut_sh}, {25'd0, tbl[i].sh});
        end

        run_cmd(8'h46, n, e);
        run_cmd(8'h46, n, e);
        chk("errcnt_three", {24'd0, err_cnt}, 32'd3);

        // back-to-back: broadcast then write with cmd_valid held throughout
        exp_q.delete();
        void'(model_cmd(8'hA3));
        void'(model_cmd(8'h66));
        @(negedge clk);
        bus.cmd_data  = 8'hA3;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_data = 8'h66;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_cyc%0d", i), {24'd0, obs()},
                {24'd0, (i < 3) ? exp_strobe(exp_q[i]) : (i == 3) ? exp_idle(1'b0)
                                                                  : exp_strobe(exp_q[3])});
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end", {24'd0, obs()}, {24'd0, exp_idle(1'b0)});
        chk("b2b_shadow", {25'd0, dut_sh}, {25'd0, m_shadows()});

        // error counter saturation: bad byte held valid, accepted every cycle
        en_cnt = 0;
        bus.cmd_data  = 8'h46;
        bus.cmd_valid = 1'b1;
        repeat (260) begin
            @(negedge clk);
            en_cnt += int'(bus.config_en);
            void'(model_cmd(8'h46));
        end
        bus.cmd_valid = 1'b0;
        chk("sat_no_strobe", 32'(en_cnt), 32'd0);
        chk("sat_errcnt", {24'd0, err_cnt}, 32'(m_err));
        chk("sat_errcnt_ff", {24'd0, err_cnt}, 32'hFF);

        // reset during the second LOAD_DEFAULTS strobe
        @(negedge clk);
        bus.cmd_data  = 8'hC0;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_s0", {24'd0, obs()}, {24'd0, exp_strobe(4'b0000)});
        @(negedge clk);
        chk("rst_mid_s1", {24'd0, obs()}, {24'd0, exp_strobe(4'b0101)});
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_out", {24'd0, obs(), bus.config_addr, bus.config_data} & 32'hFF0F,
            32'd0);
        chk("rst_mid_shadow", {25'd0, dut_sh}, 32'd0);
        chk("rst_mid_errcnt", {24'd0, err_cnt}, 32'd0);
        @(negedge clk);
        chk("rst_hold", {24'd0, obs()}, 32'd0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_release", {24'd0, obs()}, {24'd0, exp_idle(1'b0)});
        chk("rst_release_shadow", {25'd0, dut_sh}, 32'd0);

        // randomized commands, mostly with correct parity
        for (int k = 0; k < 60; k++) begin
            c = 8'($urandom);
            if ($urandom_range(3) != 0) c[5] = c[5] ^ (^c);
            run_cmd(c, n, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
